// File: rtl/nes_gamepad_reader_pkg.sv
// nes_gamepad_reader_pkg: FSM state encodings and button bit positions shared with the pad emulator and game core
package nes_gamepad_reader_pkg;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LATCH    = 3'd1;
  localparam logic [2:0] ST_SETTLE   = 3'd2;
  localparam logic [2:0] ST_PULSE_HI = 3'd3;
  localparam logic [2:0] ST_PULSE_LO = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
endpackage

// File: rtl/nes_gamepad_reader_sync.sv
// nes_gamepad_reader_sync: generic 2-flop synchroniser
//   clk_i, rst_i (async, active-high), d_i asynchronous input, q_o synchronised output.
//   RST_VAL is the value both flops take in reset (1 = serial line idle-high).
module nes_gamepad_reader_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ff_q <= {2{RST_VAL}};
    else ff_q <= {ff_q[0], d_i};
  assign q_o = ff_q[1];
endmodule

// File: rtl/nes_gamepad_reader.sv
// nes_gamepad_reader: host-side NES pad reader; latches the pad, clocks out 8 bits, presents active-high buttons
//   clk_i clock, reset_i async active-high reset, poll_en_i continuous polling enable,
//   data_in_i serial pad data (active-low, async), latch_o / pulse_o pad strobes,
//   buttons_o [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right (1 = pressed),
//   valid_o one-cycle strobe asserted in the cycle buttons_o takes a new frame.
module nes_gamepad_reader
  import nes_gamepad_reader_pkg::*;
#(
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300,
  parameter int POLL_CYCLES  = 833333
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       poll_en_i,
  input  logic       data_in_i,
  output logic       latch_o,
  output logic       pulse_o,
  output logic [7:0] buttons_o,
  output logic       valid_o
);
  localparam int M1   = LATCH_CYCLES > HALF_CYCLES ? LATCH_CYCLES : HALF_CYCLES;
  localparam int MAXC = M1 > POLL_CYCLES ? M1 : POLL_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] LATCH_END = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] HALF_END  = CW'(HALF_CYCLES - 1);
  localparam logic [CW-1:0] POLL_END  = CW'(POLL_CYCLES - 1);
  logic [2:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] buttons_q;
  logic latch_q, pulse_q, valid_q;
  logic data_s, sample;
  nes_gamepad_reader_sync #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (reset_i),
    .d_i   (data_in_i),
    .q_o   (data_s)
  );
  // Pad drives 0 for pressed.
  assign sample = ~data_s;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sr_d    = sr_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = (!poll_en_i || cnt_q == POLL_END) ? '0 : cnt_q + 1'b1;
        if (poll_en_i && cnt_q == POLL_END) state_d = ST_LATCH;
      end
      ST_LATCH:
        if (cnt_q == LATCH_END) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      ST_SETTLE:
        if (cnt_q == HALF_END) begin
          state_d = ST_PULSE_HI;
          cnt_d   = '0;
          sr_d[0] = sample;
          bit_d   = 3'd1;
        end
      ST_PULSE_HI:
        if (cnt_q == HALF_END) begin
          state_d = ST_PULSE_LO;
          cnt_d   = '0;
        end
      ST_PULSE_LO:
        if (cnt_q == HALF_END) begin
          cnt_d       = '0;
          sr_d[bit_q] = sample;
          state_d     = bit_q == 3'd7 ? ST_DONE : ST_PULSE_HI;
          bit_d       = bit_q == 3'd7 ? bit_q : bit_q + 3'd1;
        end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  // Strobes are registered from the next state so they line up exactly with the state they belong to.
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sr_q      <= '0;
      buttons_q <= '0;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      latch_q   <= state_d == ST_LATCH;
      pulse_q   <= state_d == ST_PULSE_HI;
      valid_q   <= state_d == ST_DONE;
      if (state_d == ST_DONE) buttons_q <= sr_d;
    end
  assign latch_o   = latch_q;
  assign pulse_o   = pulse_q;
  assign buttons_o = buttons_q;
  assign valid_o   = valid_q;
endmodule

// File: tb/tb_nes_gamepad_reader.sv
// tb_nes_gamepad_reader: directed vectors against a behavioural pad model
module tb_nes_gamepad_reader;
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic poll_en_i = 1'b1;
  logic data_in_i;
  logic latch_o, pulse_o, valid_o;
  logic [7:0] buttons_o;
  logic [1:0] mode = 2'd0;
  logic [7:0] pattern = 8'h00;
  logic [7:0] pad_sr = 8'h00;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0, pulses = 0, overlaps = 0, latch_cyc = 0, valid_cyc = 0, latch_hi = 0;
  logic pl = 1'b0, pp = 1'b0;

  nes_gamepad_reader #(.LATCH_CYCLES(4), .HALF_CYCLES(4), .POLL_CYCLES(10)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .poll_en_i (poll_en_i),
    .data_in_i (data_in_i),
    .latch_o   (latch_o),
    .pulse_o   (pulse_o),
    .buttons_o (buttons_o),
    .valid_o   (valid_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge latch_o or posedge pulse_o)
    pad_sr <= latch_o ? pattern : pad_sr >> 1;
  assign data_in_i = mode == 2'd0 ? ~pad_sr[0] : mode == 2'd1;

  always @(negedge clk_i) begin
    cyc <= cyc + 1;
    if (latch_o && !pl) latch_cyc <= cyc + 1;
    pulses <= (latch_o && !pl) ? 0 : pulses + int'(pulse_o && !pp);
    if (latch_o && pulse_o) overlaps <= overlaps + 1;
    if (latch_o) latch_hi <= latch_hi + 1;
    if (valid_o) valid_cyc <= cyc + 1;
    pl <= latch_o;
    pp <= pulse_o;
  end

  typedef struct {
    logic [1:0] mode;
    logic [7:0] pat;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic wait_valid();
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      got = valid_o;
    end
    chk("valid_seen", 32'(got), 32'd1);
  endtask

  initial begin
    int prev_valid, l0;
    bit got;
    vecs[0] = '{2'd0, 8'h09, 8'h09};
    vecs[1] = '{2'd1, 8'h00, 8'h00};
    vecs[2] = '{2'd2, 8'h00, 8'hFF};
    vecs[3] = '{2'd0, 8'h80, 8'h80};
    vecs[4] = '{2'd0, 8'hA5, 8'hA5};
    vecs[5] = '{2'd0, 8'h5A, 8'h5A};
    repeat (2) tick();
    chk("rst_latch", 32'(latch_o), 0);
    chk("rst_pulse", 32'(pulse_o), 0);
    chk("rst_buttons", 32'(buttons_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    reset_i = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk($sformatf("latch_edge%0d", k), 32'(latch_o), 32'(k >= 10 && k <= 13));
      if (k == 9) begin
        chk("pre_buttons", 32'(buttons_o), 0);
        chk("pre_valid", 32'(valid_o), 0);
      end
    end
    wait_valid();
    chk("first_buttons", 32'(buttons_o), 0);
    chk("first_pulses", 32'(pulses), 7);
    prev_valid = valid_cyc;
    tick();
    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode;
      pattern = vecs[i].pat;
      wait_valid();
      chk($sformatf("v%0d_buttons", i), 32'(buttons_o), 32'(vecs[i].exp));
      chk($sformatf("v%0d_pulses", i), 32'(pulses), 7);
      chk($sformatf("v%0d_latch_to_valid", i), 32'(valid_cyc - latch_cyc), 64);
      chk($sformatf("v%0d_period", i), 32'(valid_cyc - prev_valid), 75);
      prev_valid = valid_cyc;
      tick();
      chk($sformatf("v%0d_valid_1cyc", i), 32'(valid_o), 0);
      chk($sformatf("v%0d_hold", i), 32'(buttons_o), 32'(vecs[i].exp));
    end
    mode = 2'd0;
    pattern = 8'h3C;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      got = pulse_o && pulses == 3;
    end
    chk("third_pulse_seen", 32'(got), 1);
    reset_i = 1'b1;
    #1;
    chk("midrst_pulse", 32'(pulse_o), 0);
    chk("midrst_latch", 32'(latch_o), 0);
    chk("midrst_buttons", 32'(buttons_o), 0);
    chk("midrst_valid", 32'(valid_o), 0);
    tick();
    reset_i = 1'b0;
    wait_valid();
    chk("postrst_buttons", 32'(buttons_o), 32'h3C);
    chk("postrst_pulses", 32'(pulses), 7);
    chk("postrst_latch_to_valid", 32'(valid_cyc - latch_cyc), 64);
    poll_en_i = 1'b0;
    l0 = latch_hi;
    repeat (200) tick();
    chk("idle_no_latch", 32'(latch_hi - l0), 0);
    chk("idle_no_valid", 32'(valid_o), 0);
    pattern = 8'h42;
    poll_en_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      got = latch_o;
    end
    chk("resume_latch", 32'(got), 1);
    poll_en_i = 1'b0;
    wait_valid();
    chk("drain_buttons", 32'(buttons_o), 32'h42);
    chk("drain_pulses", 32'(pulses), 7);
    l0 = latch_hi;
    repeat (200) tick();
    chk("drain_no_latch", 32'(latch_hi - l0), 0);
    chk("drain_hold", 32'(buttons_o), 32'h42);
    chk("no_overlap", 32'(overlaps), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
